// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 128-bit memory port between I-cache and D-cache.
// Define ARB_RR_EN for round-robin; default build gives the D-cache priority.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              ic_read,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_ready,
  input  logic              dc_read,
  input  logic              dc_write,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {
    IDLE,
    GNT_I,
    GNT_D
  } state_t;

  state_t state;
  logic   ic_req;
  logic   dc_req;
  logic   ic_win;

  assign ic_req = ic_read;
  assign dc_req = dc_read | dc_write;

`ifdef ARB_RR_EN
  logic rr_last_dc;
  assign ic_win = ic_req & (~dc_req | rr_last_dc);
`else
  assign ic_win = ic_req & ~dc_req;
`endif

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state     <= IDLE;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef ARB_RR_EN
      rr_last_dc <= 1'b1;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (ic_win) begin
            state     <= GNT_I;
            mem_read  <= 1'b1;
            mem_write <= 1'b0;
            mem_addr  <= ic_addr;
          end else if (dc_req) begin
            // write-back first; the allocate read comes back later
            state     <= GNT_D;
            mem_read  <= ~dc_write;
            mem_write <= dc_write;
            mem_addr  <= dc_addr;
            if (dc_write) mem_wdata <= dc_wdata;
          end
        end
        GNT_I, GNT_D: begin
          if (mem_ready) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
`ifdef ARB_RR_EN
            rr_last_dc <= (state == GNT_D);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ic_ready = (state == GNT_I) & mem_ready;
  assign dc_ready = (state == GNT_D) & mem_ready;
  assign ic_rdata = mem_rdata;
  assign dc_rdata = mem_rdata;

endmodule
